// File: rtl/sdram_test_supervisor_pkg.sv
// sdram_test_pkg: shared state encodings and LED bit positions for the SDRAM test supervisor
package sdram_test_pkg;
   localparam logic [2:0] S_POWERUP    = 3'd0;
   localparam logic [2:0] S_INIT       = 3'd1;
   localparam logic [2:0] S_WAIT_READY = 3'd2;
   localparam logic [2:0] S_RUN        = 3'd3;
   localparam logic [2:0] S_TIMEOUT    = 3'd4;
   localparam int LED_HB   = 0;
   localparam int LED_PASS = 1;
   localparam int LED_FAIL = 2;
endpackage

// File: rtl/sdram_test_supervisor_if.sv
// sdram_test_supervisor_if: init/ready/running/error link between the supervisor (master) and the test engine (slave)
interface sdram_test_supervisor_if;
   logic init;
   logic ready;
   logic running;
   logic error;
   modport master (output init, input ready, running, error);
   modport slave (input init, output ready, running, error);
endinterface

// File: rtl/sdram_sup_edge.sv
// sdram_sup_edge: 1-bit rise (FALL=0) or fall (FALL=1) detector; history loads on en, clears on clr
module sdram_sup_edge #(
   parameter bit FALL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic ev
);
   logic prev;
   always_ff @(posedge clock or posedge reset)
      if (reset) prev <= 1'b0;
      else if (clr) prev <= 1'b0;
      else if (en) prev <= d;
   assign ev = FALL ? prev & ~d : d & ~prev;
endmodule

// File: rtl/sdram_test_supervisor.sv
// sdram_test_supervisor: power-up/init sequencing, ready timeout and pass/error monitoring of the SDRAM test engine
// Optional macro SDRAM_SUP_FIRST_ERR_EN adds first_err_cycle/first_err_pass capture.
module sdram_test_supervisor
   import sdram_test_pkg::*;
#(
   parameter int POWERUP_CYCLES = 20000,
   parameter int INIT_CYCLES    = 4,
   parameter int READY_TIMEOUT  = 64,
   parameter int ERR_W          = 16,
   parameter int PASS_W         = 8,
   parameter int BLINK_DIV      = 24
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   sdram_test_supervisor_if.master eng,
   output logic                  busy,
   output logic                  fail,
   output logic                  timeout,
   output logic [PASS_W-1:0]     pass_count,
   output logic [ERR_W-1:0]      err_count,
   output logic [2:0]            led
`ifdef SDRAM_SUP_FIRST_ERR_EN
   ,
   output logic [31:0]           first_err_cycle,
   output logic [PASS_W-1:0]     first_err_pass
`endif
);
   logic [2:0] state, nxt;
   logic [31:0] cnt;
   logic restart, run, err_rise, run_fall, err_ev, pass_ev, wrapped;
   logic fail_n, wrap_n;
   logic [ERR_W-1:0] err_n;
   logic [PASS_W-1:0] pass_n;
   assign run = state == S_RUN;
   assign restart = start && state != S_INIT;
   assign err_ev = run && err_rise;
   assign pass_ev = run && run_fall;
   // history tracks inputs only while (entering) RUN, so the entry cycle never yields a false edge
   sdram_sup_edge #(.FALL(1'b0)) u_err (.clock(clock), .reset(reset), .clr(restart), .en(nxt == S_RUN), .d(eng.error), .ev(err_rise));
   sdram_sup_edge #(.FALL(1'b1)) u_run (.clock(clock), .reset(reset), .clr(restart), .en(nxt == S_RUN), .d(eng.running), .ev(run_fall));
   always_comb begin
      nxt = restart ? S_INIT :
            state == S_POWERUP && cnt == 32'(POWERUP_CYCLES - 1) ? S_INIT :
            state == S_INIT && cnt == 32'(INIT_CYCLES - 1) ? S_WAIT_READY :
            state == S_WAIT_READY && eng.ready ? S_RUN :
            state == S_WAIT_READY && cnt == 32'(READY_TIMEOUT - 1) ? S_TIMEOUT : state;
      fail_n = restart ? 1'b0 : fail | err_ev;
      err_n = restart ? '0 : err_count + ERR_W'(err_ev && !(&err_count));
      pass_n = restart ? '0 : pass_count + PASS_W'(pass_ev);
      wrap_n = restart ? 1'b0 : wrapped | (pass_ev && &pass_count);
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= S_POWERUP;
         cnt <= '0;
         eng.init <= 1'b0;
         busy <= 1'b1;
         timeout <= 1'b0;
         fail <= 1'b0;
         err_count <= '0;
         pass_count <= '0;
         wrapped <= 1'b0;
         led <= '0;
      end else begin
         state <= nxt;
         cnt <= nxt != state ? '0 : cnt + 1;
         eng.init <= nxt == S_INIT;
         busy <= nxt != S_RUN && nxt != S_TIMEOUT;
         timeout <= nxt == S_TIMEOUT;
         fail <= fail_n;
         err_count <= err_n;
         pass_count <= pass_n;
         wrapped <= wrap_n;
         // cnt restarts on every state change, so its low bits double as the blink dividers
         led[LED_HB] <= nxt == S_RUN && (run && &cnt[BLINK_DIV-1:0] ? ~led[LED_HB] : led[LED_HB]);
         led[LED_PASS] <= (pass_n != '0 || wrap_n) && !fail_n;
         led[LED_FAIL] <= fail_n || (nxt == S_TIMEOUT && (state == S_TIMEOUT && &cnt[BLINK_DIV-3:0] ? ~led[LED_FAIL] : led[LED_FAIL]));
      end
`ifdef SDRAM_SUP_FIRST_ERR_EN
   logic [31:0] cyc;
   logic got;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         cyc <= '0;
         got <= 1'b0;
         first_err_cycle <= '0;
         first_err_pass <= '0;
      end else begin
         cyc <= nxt == S_RUN && !run ? '0 : run && !(&cyc) ? cyc + 1 : cyc;
         if (restart) begin
            got <= 1'b0;
            first_err_cycle <= '0;
            first_err_pass <= '0;
         end else if (err_ev && !got) begin
            got <= 1'b1;
            first_err_cycle <= cyc;
            first_err_pass <= pass_count;
         end
      end
`endif
endmodule

// File: doc/sdram_test_supervisor.md
Name: sdram_test_supervisor

Overview:
Control and status stage that sits directly upstream and downstream of the SDRAM test engine.
- Upstream: waits out power-up, then issues the rising-edge `init` that starts the engine, and watches for `ready` with a timeout.
- Downstream: consumes the engine's `ready`/`running`/`error` outputs, counts completed passes and error events, and drives pass/fail/heartbeat LEDs.

Parameters:
- POWERUP_CYCLES, 20000, cycles held idle after reset before the first init (≥1).
- INIT_CYCLES, 4, cycles `init` is held high (≥2).
- READY_TIMEOUT, 64, cycles allowed from init falling to `ready` high (≥1).
- ERR_W, 16, error-event counter width.
- PASS_W, 8, pass counter width.
- BLINK_DIV, 24, heartbeat divider bit index (LED toggles every 2^BLINK_DIV cycles).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, single-cycle restart request (synchronous).
- init, out, 1, init strobe to the test engine.
- ready, in, 1, engine initialisation complete.
- running, in, 1, engine address bit 22; a falling edge marks one completed pass.
- error, in, 1, engine registered compare-mismatch flag.
- busy, out, 1, high in every state except RUN and TIMEOUT.
- fail, out, 1, sticky: at least one error seen since the last (re)start.
- timeout, out, 1, `ready` did not arrive in time.
- pass_count, out, PASS_W, completed passes (wraps).
- err_count, out, ERR_W, error rising edges (saturates).
- led, out, 3, [0] heartbeat, [1] pass, [2] fail/timeout.

Behaviour:
Reset and clocking:
- reset is asynchronous, active-high; clock is `clock`. All outputs are registered.
- Reset values: state=POWERUP, init=0, busy=1, fail=0, timeout=0, pass_count=0, err_count=0, led=000. Input edge-history registers clear to 0.

FSM states:
- POWERUP: init=0; counts POWERUP_CYCLES, then goes to INIT.
- INIT: init=1 for exactly INIT_CYCLES cycles, then goes to WAIT_READY. The engine sees the low→high edge on the first INIT cycle.
- WAIT_READY: init=0; timeout counter runs.
  - `ready`=1 sampled → RUN.
  - READY_TIMEOUT cycles elapse without `ready` → TIMEOUT, timeout=1.
  - `ready` sampled on the first WAIT_READY cycle counts as valid.
- RUN: busy=0; monitoring active. Remains here until `start` or reset.
- TIMEOUT: terminal; busy=0, timeout=1. Left only via `start` or reset.

start handling:
- Honoured in POWERUP, WAIT_READY, RUN and TIMEOUT; ignored in INIT so the edge pulse is never truncated.
- Next state is INIT (power-up wait skipped). Clears fail, timeout, pass_count, err_count, and the edge-history registers.

Monitoring (RUN only):
- Inputs are sampled into 1-cycle history registers.
- error rising edge (error=1, prev=0) → err_count+1, saturating at all-ones; fail=1 the same cycle the count updates (1 cycle after the edge).
- Consecutive failing addresses with error held high count as one event; this is intended.
- running falling edge → pass_count+1, wrapping modulo 2^PASS_W.
- Edges occurring outside RUN are not counted. On entry to RUN, history registers are loaded with the current inputs so no false edge is detected.
- error and running edges in the same cycle both update.

LEDs:
- led[0] toggles every 2^BLINK_DIV cycles in RUN; 0 elsewhere.
- led[1] = (pass_count≠0 or pass_wrapped) and !fail. pass_wrapped is sticky, set on pass_count overflow, cleared with the counters.
- led[2]:
  - fail → solid 1.
  - timeout → blinks at 2^(BLINK_DIV-2).
  - otherwise 0.

Reset mid-operation returns to POWERUP and drives init=0 immediately (asynchronously).

Optional Feature:
SDRAM_SUP_FIRST_ERR_EN
- Defined:
  - Adds output first_err_cycle[31:0] and first_err_pass[PASS_W-1:0].
  - A free-running 32-bit cycle counter clears on RUN entry and saturates at all-ones.
  - On the first counted error edge after (re)start, the cycle counter value and pass_count are latched; later errors do not change them.
  - Both outputs reset/clear to 0.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sdram_test_pkg:
  - state encoding constants S_POWERUP=0, S_INIT=1, S_WAIT_READY=2, S_RUN=3, S_TIMEOUT=4 (3 bits);
  - LED index constants LED_HB=0, LED_PASS=1, LED_FAIL=2.
- One natural sub-module: sdram_sup_edge, a 1-bit rise/fall detector with a synchronous load-on-enable. It is instantiated for error and running.

Test Plan (POWERUP_CYCLES=10, INIT_CYCLES=4, READY_TIMEOUT=8, BLINK_DIV=3):
1. Release reset, tie ready high after init falls. Require: init=1 exactly on cycles 11–14, busy falls on the cycle after ready is sampled, state=RUN.
2. Hold ready=0. Require: timeout=1 and busy=0 at 8 cycles after init falls; led[2] toggles every 2 cycles; `start` then gives init=1 on the next cycle with timeout=0.
3. In RUN, error pulses high for 32 cycles, three times. Require err_count=3, fail=1, led[2]=1, led[1]=0.
4. In RUN, drive 2^PASS_W+1 falling edges on running. Require pass_count=1, led[1]=1, no error.
5. Hold ERR_W=2 and apply 6 error edges → err_count=3 (saturated). Assert `start` during INIT → ignored, init stays high for a total of 4 cycles.
6. With SDRAM_SUP_FIRST_ERR_EN, first error edge 20 cycles into RUN after 2 passes. Require first_err_cycle=20, first_err_pass=2, unchanged by later errors. Assert reset mid-RUN → all outputs at reset values, init=0 immediately.
